// File: rtl/power_ctrl_multi_sm.sv
// Power-shut-off sequencer: one FSM per switchable domain, plus a shared inrush arbiter
// that lets only one domain at a time ramp its supply back up.
module power_ctrl_multi_sm #(
  parameter int NUM_DOM      = 4,
  parameter int CLK_WAIT_CYC = 1,
  parameter int PWR2_DLY     = 1,
  parameter int STAB_CYC     = 16
) (
  input  logic               pclk,
  input  logic               prst,
  input  logic [NUM_DOM-1:0] l1_req,
  output logic [NUM_DOM-1:0] set_status,
  output logic [NUM_DOM-1:0] clr_status,
  output logic [NUM_DOM-1:0] pso_ack,
  output logic [NUM_DOM-1:0] gate_clk,
  output logic [NUM_DOM-1:0] isolate,
  output logic [NUM_DOM-1:0] save_edge,
  output logic [NUM_DOM-1:0] restore_edge,
  output logic [NUM_DOM-1:0] rstn_non_srpg,
  output logic [NUM_DOM-1:0] pwr1_on,
  output logic [NUM_DOM-1:0] pwr2_on,
  output logic               pwrup_busy
);

  localparam int MAX_AB = (CLK_WAIT_CYC > PWR2_DLY) ? CLK_WAIT_CYC : PWR2_DLY;
  localparam int MAXC   = (MAX_AB > STAB_CYC) ? MAX_AB : STAB_CYC;
  localparam int CW     = $clog2(MAXC + 1);

  localparam logic [CW-1:0] LD_WAIT = CW'(CLK_WAIT_CYC);
  localparam logic [CW-1:0] LD_PWR2 = CW'(PWR2_DLY);
  localparam logic [CW-1:0] LD_STAB = CW'(STAB_CYC);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [3:0] {
    IDLE, CLK_OFF, WAIT1, ISOLATE, SAVE, PRE_OFF, OFF, PWR_ON1,
    PWR_ON2, RESTORE, WAIT2, DE_ISO, CLK_ON, WAIT3, RST_CLR, ABORT
  } state_e;

  state_e        state_q [NUM_DOM];
  state_e        state_d [NUM_DOM];
  logic [CW-1:0] cnt_q   [NUM_DOM];
  logic [CW-1:0] cnt_d   [NUM_DOM];

  logic [NUM_DOM-1:0] grant;
  logic               busy_now;
  logic               busy_d;

  logic [NUM_DOM-1:0] set_status_q, clr_status_q, pso_ack_q, gate_clk_q, isolate_q;
  logic [NUM_DOM-1:0] save_edge_q, restore_edge_q, rstn_q, pwr1_on_q, pwr2_on_q;
  logic               busy_q;

  // Arbiter looks only at registered state, so a new ramp starts the cycle after the
  // previous domain has left PWR_ON2.
  always_comb begin
    busy_now = 1'b0;
    for (int i = 0; i < NUM_DOM; i++) begin
      if (state_q[i] == PWR_ON1 || state_q[i] == PWR_ON2) busy_now = 1'b1;
    end
  end

  always_comb begin
    logic found;
    found = 1'b0;
    grant = '0;
    if (!busy_now) begin
      for (int i = 0; i < NUM_DOM; i++) begin
        if (!found && state_q[i] == OFF && !l1_req[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy_d = 1'b0;
    for (int i = 0; i < NUM_DOM; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        IDLE:    if (l1_req[i]) state_d[i] = CLK_OFF;
        CLK_OFF: begin
          if (!l1_req[i]) begin
            state_d[i] = ABORT;
          end else begin
            state_d[i] = WAIT1;
            cnt_d[i]   = LD_WAIT;
          end
        end
        WAIT1: begin
          if (!l1_req[i])               state_d[i] = ABORT;
          else if (cnt_q[i] == CNT_ONE) state_d[i] = ISOLATE;
          else                          cnt_d[i]   = cnt_q[i] - CNT_ONE;
        end
        ISOLATE: state_d[i] = SAVE;
        SAVE:    state_d[i] = PRE_OFF;
        PRE_OFF: state_d[i] = OFF;
        OFF: begin
          if (grant[i]) begin
            state_d[i] = PWR_ON1;
            cnt_d[i]   = LD_PWR2;
          end
        end
        PWR_ON1: begin
          if (cnt_q[i] == CNT_ONE) begin
            state_d[i] = PWR_ON2;
            cnt_d[i]   = LD_STAB;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_ONE;
          end
        end
        PWR_ON2: begin
          if (cnt_q[i] == CNT_ONE) state_d[i] = RESTORE;
          else                     cnt_d[i]   = cnt_q[i] - CNT_ONE;
        end
        RESTORE: state_d[i] = WAIT2;
        WAIT2:   state_d[i] = DE_ISO;
        DE_ISO:  state_d[i] = CLK_ON;
        CLK_ON:  state_d[i] = WAIT3;
        WAIT3:   state_d[i] = RST_CLR;
        RST_CLR: state_d[i] = IDLE;
        ABORT:   state_d[i] = IDLE;
        default: state_d[i] = IDLE;
      endcase
      if (state_d[i] == PWR_ON1 || state_d[i] == PWR_ON2) busy_d = 1'b1;
    end
  end

  // Outputs are decoded from next state so they line up with the cycle the FSM sits in.
  always_ff @(posedge pclk) begin
    if (prst) begin
      for (int i = 0; i < NUM_DOM; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      set_status_q   <= '0;
      clr_status_q   <= '0;
      pso_ack_q      <= '0;
      gate_clk_q     <= '0;
      isolate_q      <= '0;
      save_edge_q    <= '0;
      restore_edge_q <= '0;
      rstn_q         <= '0;
      pwr1_on_q      <= '1;
      pwr2_on_q      <= '1;
      busy_q         <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DOM; i++) begin
        state_q[i]        <= state_d[i];
        cnt_q[i]          <= cnt_d[i];
        set_status_q[i]   <= (state_d[i] == CLK_OFF);
        clr_status_q[i]   <= (state_d[i] inside {RST_CLR, ABORT});
        pso_ack_q[i]      <= (state_d[i] == OFF);
        gate_clk_q[i]     <= (state_d[i] inside {CLK_OFF, WAIT1, ISOLATE, SAVE, PRE_OFF, OFF,
                                                 PWR_ON1, PWR_ON2, RESTORE, WAIT2, DE_ISO});
        isolate_q[i]      <= (state_d[i] inside {ISOLATE, SAVE, PRE_OFF, OFF, PWR_ON1,
                                                 PWR_ON2, RESTORE, WAIT2});
        save_edge_q[i]    <= (state_d[i] == SAVE);
        restore_edge_q[i] <= (state_d[i] == RESTORE);
        rstn_q[i]         <= !(state_d[i] inside {OFF, PWR_ON1, PWR_ON2, RESTORE, WAIT2,
                                                  DE_ISO, CLK_ON, WAIT3});
        pwr1_on_q[i]      <= (state_d[i] != OFF);
        pwr2_on_q[i]      <= !(state_d[i] inside {OFF, PWR_ON1});
      end
      busy_q <= busy_d;
    end
  end

  assign set_status    = set_status_q;
  assign clr_status    = clr_status_q;
  assign pso_ack       = pso_ack_q;
  assign gate_clk      = gate_clk_q;
  assign isolate       = isolate_q;
  assign save_edge     = save_edge_q;
  assign restore_edge  = restore_edge_q;
  assign rstn_non_srpg = rstn_q;
  assign pwr1_on       = pwr1_on_q;
  assign pwr2_on       = pwr2_on_q;
  assign pwrup_busy    = busy_q;

endmodule
